// File: rtl/tile_write_arbiter_pkg.sv
// Shared definitions for the tile write arbiter: FSM state encodings,
// quadrant tile position codes and the tile value width.
package tile_write_arbiter_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    localparam logic [1:0] POS_TL = 2'b00;
    localparam logic [1:0] POS_BL = 2'b01;
    localparam logic [1:0] POS_TR = 2'b10;
    localparam logic [1:0] POS_BR = 2'b11;

    localparam int TILE_W = 16;

endpackage

// File: rtl/tile_write_arbiter_rr_pick.sv
// Combinational round-robin picker.  Searches the request vector upward
// starting one above the pointer (wrapping modulo N) and returns the first
// requester found.
//   req     in   N      request vector
//   ptr     in   IDX_W  last served requester
//   onehot  out  N      one-hot winner (0 when nothing requests)
//   idx     out  IDX_W  winner index (0 when nothing requests)
//   any     out  1      at least one request present
module tile_write_arbiter_rr_pick
    import tile_write_arbiter_pkg::*;
#(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = '0;
        // i runs 1..N so the pointer itself is visited last.
        for (int i = 1; i <= N; i++) begin
            cand = IDX_W'((int'(ptr) + i) % N);
            if (!any && req[cand]) begin
                any          = 1'b1;
                onehot[cand] = 1'b1;
                idx          = cand;
            end
        end
    end

endmodule

// File: rtl/tile_write_arbiter.sv
// Round-robin burst arbiter for the single quadrant-tile write port of the
// cell array.  A winning source owns the port until it marks a beat as last
// or until BURST_MAX beats have been accepted (forced release with abort).
// New bursts are not started while the life engine is busy.
//   clk          in   1             clock
//   reset        in   1             synchronous, active-high reset
//   req          in   N_REQ         per-source request / beat valid
//   req_pos      in   2*N_REQ       tile position of source i at [2i+1:2i]
//   req_val      in   16*N_REQ      tile value of source i at [16i+15:16i]
//   req_last     in   N_REQ         current beat of source i ends its burst
//   engine_busy  in   1             life engine mid-generation
//   gnt          out  N_REQ         one-hot beat accept (combinational)
//   pos          out  2             registered tile position
//   val          out  16            registered tile value
//   write_enb    out  1             registered array write strobe
//   busy         out  1             registered, burst owned
//   abort        out  1             registered, burst force-released
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no owner; arbitrate among requests when engine is idle
// ST_BURST | owner holds the port; its beats are accepted when req high
module tile_write_arbiter
    import tile_write_arbiter_pkg::*;
#(
    parameter int N_REQ     = 3,
    parameter int BURST_MAX = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [2*N_REQ-1:0]        req_pos,
    input  logic [TILE_W*N_REQ-1:0]   req_val,
    input  logic [N_REQ-1:0]          req_last,
    input  logic                      engine_busy,
    output logic [N_REQ-1:0]          gnt,
    output logic [1:0]                pos,
    output logic [TILE_W-1:0]         val,
    output logic                      write_enb,
    output logic                      busy,
    output logic                      abort
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_t       state, state_next;
    logic [IDX_W-1:0] owner;
    logic [N_REQ-1:0] owner_oh;
    logic [IDX_W-1:0] rr_ptr;
    logic [7:0]       count;
    logic [7:0]       count_inc;

    logic [N_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    logic             start;
    logic             beat;
    logic             end_burst;
    logic             forced;

    logic [1:0]        pos_arr [N_REQ];
    logic [TILE_W-1:0] val_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign pos_arr[g] = req_pos[2*g +: 2];
        assign val_arr[g] = req_val[TILE_W*g +: TILE_W];
    end

    tile_write_arbiter_rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign count_inc = count + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        beat       = 1'b0;
        end_burst  = 1'b0;
        forced     = 1'b0;
        gnt        = '0;
        case (state)
            ST_IDLE: begin
                if (pick_any && !engine_busy) begin
                    start      = 1'b1;
                    state_next = ST_BURST;
                end
            end
            ST_BURST: begin
                beat = req[owner];
                gnt  = owner_oh & req;
                if (beat) begin
                    if (req_last[owner]) begin
                        end_burst  = 1'b1;
                        state_next = ST_IDLE;
                    end else if (count_inc == 8'(BURST_MAX)) begin
                        end_burst  = 1'b1;
                        forced     = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // A reset cycle must not look like an accepted beat to the source.
        if (reset) begin
            gnt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner     <= '0;
            owner_oh  <= '0;
            rr_ptr    <= IDX_W'(N_REQ - 1);
            count     <= '0;
            pos       <= '0;
            val       <= '0;
            write_enb <= 1'b0;
            busy      <= 1'b0;
            abort     <= 1'b0;
        end else begin
            if (start) begin
                owner    <= pick_idx;
                owner_oh <= pick_onehot;
                count    <= '0;
            end else if (beat) begin
                count <= count_inc;
            end
            if (end_burst) begin
                rr_ptr <= owner;
            end
            if (beat) begin
                pos <= pos_arr[owner];
                val <= val_arr[owner];
            end
            write_enb <= beat;
            busy      <= (state_next == ST_BURST);
            abort     <= forced;
        end
    end

endmodule

// File: tb/tb_tile_write_arbiter.sv
module tb_tile_write_arbiter;
    import tile_write_arbiter_pkg::*;

    localparam int N_REQ     = 3;
    localparam int BURST_MAX = 8;

    logic                    clk;
    logic                    reset;
    logic [N_REQ-1:0]        req;
    logic [2*N_REQ-1:0]      req_pos;
    logic [16*N_REQ-1:0]     req_val;
    logic [N_REQ-1:0]        req_last;
    logic                    engine_busy;
    logic [N_REQ-1:0]        gnt;
    logic [1:0]              pos;
    logic [15:0]             val;
    logic                    write_enb;
    logic                    busy;
    logic                    abort;

    int tests = 0;
    int fails = 0;

    tile_write_arbiter #(
        .N_REQ     (N_REQ),
        .BURST_MAX (BURST_MAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_pos     (req_pos),
        .req_val     (req_val),
        .req_last    (req_last),
        .engine_busy (engine_busy),
        .gnt         (gnt),
        .pos         (pos),
        .val         (val),
        .write_enb   (write_enb),
        .busy        (busy),
        .abort       (abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish, failed=%0d", fails);
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input logic [1:0] p, input logic [15:0] v);
        req_pos[2*i +: 2]  = p;
        req_val[16*i +: 16] = v;
    endtask

    logic [1:0]  t1_pos [4];
    logic [15:0] t1_val [4];
    logic [2:0]  rr_gnt [12];
    logic [2:0]  rr_last [12];

    initial begin
        t1_pos = '{POS_TL, POS_BL, POS_TR, POS_BR};
        t1_val = '{16'h6E88, 16'h0000, 16'h0886, 16'h033E};
        rr_gnt  = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b100, 3'b100,
                    3'b000, 3'b001, 3'b001, 3'b000, 3'b100, 3'b100};
        rr_last = '{3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b100,
                    3'b000, 3'b000, 3'b001, 3'b000, 3'b000, 3'b100};

        reset = 1'b1;
        req = '0; req_pos = '0; req_val = '0; req_last = '0; engine_busy = 1'b0;
        tick();
        tick();
        chk("rst_gnt", 48'(gnt), 48'h0);
        chk("rst_we", 48'(write_enb), 48'h0);
        chk("rst_pos", 48'(pos), 48'h0);
        chk("rst_val", 48'(val), 48'h0);
        chk("rst_busy", 48'(busy), 48'h0);
        chk("rst_abort", 48'(abort), 48'h0);
        reset = 1'b0;

        // Single four-beat burst from requester 0.
        req = 3'b001;
        set_src(0, t1_pos[0], t1_val[0]);
        #1 chk("t1_arb_gnt", 48'(gnt), 48'h0);
        tick();
        chk("t1_busy_rise", 48'(busy), 48'h1);
        chk("t1_no_we_arb", 48'(write_enb), 48'h0);
        for (int k = 0; k < 4; k++) begin
            set_src(0, t1_pos[k], t1_val[k]);
            req_last = (k == 3) ? 3'b001 : 3'b000;
            #1 chk("t1_gnt", 48'(gnt), 48'h1);
            tick();
            chk("t1_we", 48'(write_enb), 48'h1);
            chk("t1_pos", 48'(pos), 48'(t1_pos[k]));
            chk("t1_val", 48'(val), 48'(t1_val[k]));
            chk("t1_abort", 48'(abort), 48'h0);
            chk("t1_busy", 48'(busy), (k == 3) ? 48'h0 : 48'h1);
        end
        req = '0; req_last = '0;
        tick();
        chk("t1_we_off", 48'(write_enb), 48'h0);
        chk("t1_abort_off", 48'(abort), 48'h0);

        // Round robin between requesters 0 and 2, from a fresh reset.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_src(0, POS_TR, 16'hAAAA);
        set_src(2, POS_BL, 16'h5555);
        for (int c = 0; c < 12; c++) begin
            req = 3'b101;
            req_last = rr_last[c];
            #1 chk("rr_gnt", 48'(gnt), 48'(rr_gnt[c]));
            tick();
            chk("rr_we", 48'(write_enb), (rr_gnt[c] != 3'b000) ? 48'h1 : 48'h0);
            if (rr_gnt[c] != 3'b000)
                chk("rr_val", 48'(val), (rr_gnt[c] == 3'b001) ? 48'hAAAA : 48'h5555);
        end
        req = '0; req_last = '0;
        tick();

        // Engine hold-off with requester 1 (single-beat burst).
        engine_busy = 1'b1;
        req = 3'b010;
        req_last = 3'b010;
        set_src(1, POS_BR, 16'h1234);
        for (int c = 0; c < 3; c++) begin
            #1 chk("eng_hold_gnt", 48'(gnt), 48'h0);
            tick();
            chk("eng_hold_we", 48'(write_enb), 48'h0);
            chk("eng_hold_busy", 48'(busy), 48'h0);
        end
        engine_busy = 1'b0;
        #1 chk("eng_arb_gnt", 48'(gnt), 48'h0);
        tick();
        chk("eng_gnt", 48'(gnt), 48'h2);
        tick();
        chk("eng_we", 48'(write_enb), 48'h1);
        chk("eng_val", 48'(val), 48'h1234);
        chk("eng_pos", 48'(pos), 48'(POS_BR));
        req = '0; req_last = '0;
        tick();

        // Stall: requester 0 drops req for 3 cycles mid-burst; engine_busy
        // rising during the burst must not end it.
        req = 3'b001;
        set_src(0, t1_pos[0], 16'h1111);
        #1 chk("st_arb_gnt", 48'(gnt), 48'h0);
        tick();
        for (int k = 0; k < 2; k++) begin
            set_src(0, t1_pos[k], 16'h1111 * 16'(k + 1));
            #1 chk("st_gnt", 48'(gnt), 48'h1);
            tick();
            chk("st_we", 48'(write_enb), 48'h1);
            chk("st_val", 48'(val), 48'(16'h1111 * 16'(k + 1)));
        end
        req = 3'b000;
        engine_busy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1 chk("st_stall_gnt", 48'(gnt), 48'h0);
            tick();
            chk("st_stall_we", 48'(write_enb), 48'h0);
            chk("st_stall_busy", 48'(busy), 48'h1);
        end
        req = 3'b001;
        for (int k = 2; k < 4; k++) begin
            set_src(0, t1_pos[k], 16'h1111 * 16'(k + 1));
            req_last = (k == 3) ? 3'b001 : 3'b000;
            #1 chk("st_gnt2", 48'(gnt), 48'h1);
            tick();
            chk("st_we2", 48'(write_enb), 48'h1);
            chk("st_pos2", 48'(pos), 48'(t1_pos[k]));
            chk("st_val2", 48'(val), 48'(16'h1111 * 16'(k + 1)));
            chk("st_abort", 48'(abort), 48'h0);
        end
        chk("st_busy_end", 48'(busy), 48'h0);
        req = '0; req_last = '0; engine_busy = 1'b0;
        tick();

        // Forced release: rr_ptr is 0, so requester 1 beats requester 0.
        req = 3'b011;
        req_last = 3'b000;
        set_src(0, POS_TL, 16'hBEEF);
        set_src(1, POS_TL, 16'h1000);
        #1 chk("fr_arb_gnt", 48'(gnt), 48'h0);
        tick();
        for (int k = 0; k < BURST_MAX; k++) begin
            set_src(1, 2'(k), 16'h1000 + 16'(k));
            #1 chk("fr_gnt", 48'(gnt), 48'h2);
            tick();
            chk("fr_we", 48'(write_enb), 48'h1);
            chk("fr_val", 48'(val), 48'(16'h1000 + 16'(k)));
            chk("fr_abort", 48'(abort), (k == BURST_MAX - 1) ? 48'h1 : 48'h0);
            chk("fr_busy", 48'(busy), (k == BURST_MAX - 1) ? 48'h0 : 48'h1);
        end
        #1 chk("fr_idle_gnt", 48'(gnt), 48'h0);
        tick();
        chk("fr_abort_off", 48'(abort), 48'h0);
        chk("fr_we_off", 48'(write_enb), 48'h0);
        req_last = 3'b001;
        #1 chk("fr_next_gnt", 48'(gnt), 48'h1);
        tick();
        chk("fr_next_val", 48'(val), 48'hBEEF);
        req = '0; req_last = '0;
        tick();

        // Reset mid-burst after two writes; rr_ptr is 0 so requester 1 owns.
        req = 3'b011;
        set_src(1, POS_TR, 16'h7777);
        tick();
        for (int k = 0; k < 2; k++) begin
            #1 chk("rm_gnt", 48'(gnt), 48'h2);
            tick();
            chk("rm_we", 48'(write_enb), 48'h1);
        end
        reset = 1'b1;
        #1 chk("rm_rst_gnt", 48'(gnt), 48'h0);
        tick();
        chk("rm_we0", 48'(write_enb), 48'h0);
        chk("rm_pos0", 48'(pos), 48'h0);
        chk("rm_val0", 48'(val), 48'h0);
        chk("rm_busy0", 48'(busy), 48'h0);
        chk("rm_abort0", 48'(abort), 48'h0);
        reset = 1'b0;
        #1 chk("rm_arb_gnt", 48'(gnt), 48'h0);
        tick();
        chk("rm_tie_gnt", 48'(gnt), 48'h1);
        req = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
